// File: rtl/ram_responder.sv
// Word-addressed RAM responder for the ram side of cpu_ram_if.
// Answers each request with BUSY for LAT cycles, then ACCESS, and flags protocol errors.
module ram_responder #(
   parameter int LAT    = 2,
   parameter int ADDR_W = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        memREN,
   input  logic        memWEN,
   input  logic [31:0] memaddr,
   input  logic [31:0] memstore,
   output logic [1:0]  ramstate,
   output logic [31:0] ramload,
   output logic        DUT_error
);

   typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam int         DEPTH   = 1 << ADDR_W;
   localparam bit         HAS_LAT = (LAT != 0);
   localparam logic [3:0] LAT_M1  = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

   state_t            state, state_n;
   logic [3:0]        cnt, cnt_n;
   logic [31:0]       lat_addr, lat_addr_n;
   logic              lat_wen, lat_wen_n;
   logic              err_q;
   logic [31:0]       mem [DEPTH];

   logic              req, bad, match;
   logic [ADDR_W-1:0] idx;
   ramstate_t         rs;

   assign idx   = memaddr[ADDR_W+1:2];
   assign req   = memREN ^ memWEN;
   assign bad   = (memREN & memWEN) | (req & (memaddr[1:0] != 2'b00));
   assign match = (memaddr == lat_addr) && (memWEN == lat_wen);

   always_comb begin
      if (bad)
         rs = ERROR;
      else if (!req)
         rs = FREE;
      else if (!HAS_LAT || (state == WAIT && match && cnt == 4'd0))
         rs = ACCESS;
      else
         rs = BUSY;
   end

   assign ramstate  = rs;
   assign ramload   = (rs == ACCESS && memREN) ? mem[idx] : 32'h0;
   assign DUT_error = err_q;

   // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      lat_addr_n = lat_addr;
      lat_wen_n  = lat_wen;
      if (rs == ACCESS) begin
         state_n = IDLE;
      end else if (state == IDLE) begin
         if (req && !bad && HAS_LAT) begin
            lat_addr_n = memaddr;
            lat_wen_n  = memWEN;
            cnt_n      = LAT_M1;
            state_n    = WAIT;
         end
      end else begin
         if (!req || bad) begin
            state_n = IDLE;
         end else if (!match) begin
            // A changed request restarts its full latency.
            lat_addr_n = memaddr;
            lat_wen_n  = memWEN;
            cnt_n      = LAT_M1;
         end else if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         lat_addr <= 32'h0;
         lat_wen  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         lat_addr <= lat_addr_n;
         lat_wen  <= lat_wen_n;
         if (bad)
            err_q <= 1'b1;
      end
   end

   // NOTE: the storage array is deliberately cleared by reset, so it cannot map to a plain RAM macro.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= 32'h0;
      end else if (rs == ACCESS && memWEN) begin
         mem[idx] <= memstore;
      end
   end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: a LAT=2 and a LAT=0 instance share stimulus and are
// compared each cycle against a run-length reference model, plus directed expectations.
module tb_ram_responder;

   localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACCESS = 2'd2, S_ERROR = 2'd3;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        memREN = 1'b0, memWEN = 1'b0;
   logic [31:0] memaddr = 32'h0, memstore = 32'h0;
   logic [1:0]  st   [2];
   logic [31:0] ld   [2];
   logic        derr [2];

   int total = 0;
   int bad   = 0;

   // Reference model, one slot per instance.
   int          lat_of [2] = '{2, 0};
   logic [31:0] mmem   [2][256];
   logic        pv     [2];
   logic [32:0] pk     [2];
   int          run    [2];
   logic        merr   [2];
   logic [1:0]  obs_st [2];
   logic [31:0] obs_ld [2];
   logic [31:0] pool   [6] = '{32'h0, 32'h4, 32'h8, 32'h404, 32'h2, 32'h40};

   always #5 CLK = ~CLK;

   ram_responder #(.LAT(2), .ADDR_W(8)) dut2 (
      .CLK(CLK), .RST(RST), .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr),
      .memstore(memstore), .ramstate(st[0]), .ramload(ld[0]), .DUT_error(derr[0]));

   ram_responder #(.LAT(0), .ADDR_W(8)) dut0 (
      .CLK(CLK), .RST(RST), .memREN(memREN), .memWEN(memWEN), .memaddr(memaddr),
      .memstore(memstore), .ramstate(st[1]), .ramload(ld[1]), .DUT_error(derr[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 256; i++) mmem[d][i] = 32'h0;
         pv[d] = 1'b0; pk[d] = 33'h0; run[d] = 0; merr[d] = 1'b0;
      end
   endtask

   function automatic logic is_bad();
      return (memREN & memWEN) | ((memREN ^ memWEN) & (memaddr[1:0] != 2'b00));
   endfunction

   function automatic int age(int d);
      return (pv[d] && pk[d] == {memaddr, memWEN}) ? run[d] : 0;
   endfunction

   function automatic logic [1:0] m_state(int d);
      if (is_bad()) return S_ERROR;
      if (!(memREN ^ memWEN)) return S_FREE;
      return (age(d) == lat_of[d]) ? S_ACCESS : S_BUSY;
   endfunction

   // One cycle: drive at negedge, compare outputs mid-cycle, advance model to the edge.
   task automatic cyc(input logic ren, input logic wen, input logic [31:0] addr,
                      input logic [31:0] data, input bit pulse_rst = 1'b0);
      logic [1:0]  es;
      logic [31:0] el;
      @(negedge CLK);
      memREN = ren; memWEN = wen; memaddr = addr; memstore = data;
      if (pulse_rst) begin
         RST = 1'b1;
         #1;
         model_reset();
         RST = 1'b0;
         #1;
      end else begin
         #2;
      end
      for (int d = 0; d < 2; d++) begin
         es = m_state(d);
         el = (es == S_ACCESS && ren) ? mmem[d][addr[9:2]] : 32'h0;
         obs_st[d] = st[d];
         obs_ld[d] = ld[d];
         check($sformatf("state_lat%0d", lat_of[d]), {30'h0, st[d]}, {30'h0, es});
         check($sformatf("load_lat%0d", lat_of[d]), ld[d], el);
         check($sformatf("err_lat%0d", lat_of[d]), {31'h0, derr[d]}, {31'h0, merr[d]});
         if (is_bad()) merr[d] = 1'b1;
         if (es == S_ACCESS) begin
            if (wen) mmem[d][addr[9:2]] = data;
            pv[d] = 1'b0;
         end else if (es == S_BUSY) begin
            run[d] = age(d) + 1;
            pv[d]  = 1'b1;
            pk[d]  = {addr, wen};
         end else begin
            pv[d] = 1'b0;
         end
      end
      @(posedge CLK);
   endtask

   initial begin
      int op, hold;
      logic [31:0] a, dta;
      model_reset();
      #2;
      for (int d = 0; d < 2; d++) begin
         check("reset_state", {30'h0, st[d]}, {30'h0, S_FREE});
         check("reset_load", ld[d], 32'h0);
         check("reset_err", {31'h0, derr[d]}, 32'h0);
      end
      #10 RST = 1'b0;

      // Write 0x40 then read it back.
      cyc(0, 1, 32'h40, 32'hDEADBEEF); check("wr_c0", {30'h0, obs_st[0]}, {30'h0, S_BUSY});
      cyc(0, 1, 32'h40, 32'hDEADBEEF); check("wr_c1", {30'h0, obs_st[0]}, {30'h0, S_BUSY});
      cyc(0, 1, 32'h40, 32'hDEADBEEF); check("wr_c2", {30'h0, obs_st[0]}, {30'h0, S_ACCESS});
      cyc(0, 0, 32'h0, 32'h0);
      cyc(1, 0, 32'h40, 32'h0);
      cyc(1, 0, 32'h40, 32'h0);
      cyc(1, 0, 32'h40, 32'h0);       check("rd_40", obs_ld[0], 32'hDEADBEEF);

      // Address change mid-wait restarts latency.
      cyc(1, 0, 32'h8, 32'h0);
      cyc(1, 0, 32'hC, 32'h0);        check("chg_c0", {30'h0, obs_st[0]}, {30'h0, S_BUSY});
      cyc(1, 0, 32'hC, 32'h0);        check("chg_c1", {30'h0, obs_st[0]}, {30'h0, S_BUSY});
      cyc(1, 0, 32'hC, 32'h0);        check("chg_c2", {30'h0, obs_st[0]}, {30'h0, S_ACCESS});

      // Abandoned write leaves no trace.
      cyc(0, 1, 32'h10, 32'h55);
      cyc(0, 0, 32'h0, 32'h0);
      cyc(1, 0, 32'h10, 32'h0);
      cyc(1, 0, 32'h10, 32'h0);
      cyc(1, 0, 32'h10, 32'h0);       check("abandon_rd", obs_ld[0], 32'h0);

      // Aliasing of upper address bits.
      for (int i = 0; i < 3; i++) cyc(0, 1, 32'h404, 32'h1234);
      for (int i = 0; i < 3; i++) cyc(1, 0, 32'h004, 32'h0);
      check("alias_rd", obs_ld[0], 32'h1234);

      // Zero-latency instance answers in the same cycle.
      cyc(1, 0, 32'h0, 32'h0);        check("lat0_access", {30'h0, obs_st[1]}, {30'h0, S_ACCESS});
      cyc(0, 0, 32'h0, 32'h0);

      // Reset in the middle of a pending write.
      cyc(0, 1, 32'h20, 32'hAAAA);
      cyc(0, 1, 32'h20, 32'hAAAA, 1'b1); check("rst_busy", {30'h0, obs_st[0]}, {30'h0, S_BUSY});
      cyc(0, 0, 32'h0, 32'h0);        check("rst_free", {30'h0, obs_st[0]}, {30'h0, S_FREE});
      for (int i = 0; i < 3; i++) cyc(1, 0, 32'h20, 32'h0);
      check("rst_nocommit", obs_ld[0], 32'h0);

      // Protocol errors and the sticky flag.
      cyc(1, 1, 32'h0, 32'h0);        check("both_err", {30'h0, obs_st[0]}, {30'h0, S_ERROR});
      cyc(0, 0, 32'h0, 32'h0);        check("sticky1", {31'h0, derr[0]}, 32'h1);
      cyc(0, 0, 32'h0, 32'h0);        check("sticky2", {31'h0, derr[0]}, 32'h1);
      cyc(1, 0, 32'h2, 32'h0);        check("misalign", {30'h0, obs_st[0]}, {30'h0, S_ERROR});

      // Randomized traffic.
      for (int n = 0; n < 120; n++) begin
         op   = int'($urandom_range(0, 9));
         hold = int'($urandom_range(1, 4));
         a    = pool[$urandom_range(0, 5)];
         dta  = $urandom;
         for (int h = 0; h < hold; h++) begin
            if (op < 4)       cyc(1, 0, a, dta);
            else if (op < 8)  cyc(0, 1, a, (h == hold - 1) ? dta : $urandom);
            else if (op == 8) cyc(0, 0, a, dta);
            else              cyc(1, 1, a, dta);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
